// File: rtl/led_hex_uart_pkg.sv
// led_hex_uart_pkg: shared types, ASCII constants and the nibble-to-ASCII helper for the
// led_hex_uart_tx block.
//   tx_state_e       bit-level FSM state encoding (idle, start, data, stop)
//   ASCII_*          character constants used to build the hex/CRLF sequence
//   nibble_to_ascii  4-bit value -> uppercase ASCII hex digit
package led_hex_uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        if (n < 4'd10) begin
            return ASCII_0 + n8;
        end
        return ASCII_A + (n8 - 8'd10);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte with a load/done handshake.
//   clk_i   system clock, rising edge
//   rst_i   synchronous active-high reset (line returns high, frame aborted)
//   load_i  start a byte; honoured in idle and on the final stop-bit cycle
//   byte_i  byte captured when load_i is honoured
//   done_o  high during the last cycle of the stop bit (combinational)
//   tx_o    registered serial line, idles high
// The line lags the FSM by one cycle because tx is registered from the current state.
module uart_tx_byte
    import led_hex_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       tx_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             wrap;

    assign wrap = (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_o  = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d = StStart;
                    shift_d = byte_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (wrap) state_d = StData;
            end
            StData: begin
                if (wrap) begin
                    // Index wraps 7 -> 0, so it is already clear for the next byte.
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (wrap) begin
                    done_o = 1'b1;
                    // Chain straight into the next start bit with no idle gap.
                    if (load_i) begin
                        state_d = StStart;
                        shift_d = byte_i;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/led_hex_uart_tx.sv
// led_hex_uart_tx: captures an 8-bit result byte and sends it as two uppercase ASCII hex
// characters (high nibble first) on an 8N1 UART line.
//   Clock   system clock, rising edge
//   Reset   synchronous active-high reset
//   iData   byte to transmit
//   iValid  byte valid; accepted when iValid & oReady at a rising edge
//   oReady  high only when idle
//   oBusy   high from acceptance until the end of the last stop bit
//   oTx     registered serial line, idles high
// Build option: define HEX_UART_CRLF_EN to append CR, LF after the two hex characters.
module led_hex_uart_tx
    import led_hex_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oBusy,
    output logic       oTx
);

`ifdef HEX_UART_CRLF_EN
    localparam int unsigned CharW = 2;
    localparam logic [CharW-1:0] LastChar = 2'd3;
`else
    localparam int unsigned CharW = 1;
    localparam logic [CharW-1:0] LastChar = 1'd1;
`endif

    logic [7:0]       data_q, data_d;
    logic [CharW-1:0] char_q, char_d, char_nxt;
    logic             busy_q, busy_d;
    logic             load;
    logic [7:0]       load_byte;
    logic [7:0]       seq_byte;
    logic             tx_done;

    assign char_nxt = char_q + 1'b1;

    // Character following the current one in the sequence (never index 0).
    always_comb begin
        seq_byte = nibble_to_ascii(data_q[3:0]);
`ifdef HEX_UART_CRLF_EN
        unique case (char_nxt)
            2'd1:    seq_byte = nibble_to_ascii(data_q[3:0]);
            2'd2:    seq_byte = ASCII_CR;
            2'd3:    seq_byte = ASCII_LF;
            default: seq_byte = nibble_to_ascii(data_q[7:4]);
        endcase
`else
        seq_byte = char_nxt[0] ? nibble_to_ascii(data_q[3:0]) : nibble_to_ascii(data_q[7:4]);
`endif
    end

    always_comb begin
        busy_d    = busy_q;
        char_d    = char_q;
        data_d    = data_q;
        load      = 1'b0;
        load_byte = 8'h00;

        if (!busy_q) begin
            if (iValid) begin
                busy_d    = 1'b1;
                data_d    = iData;
                char_d    = '0;
                load      = 1'b1;
                // Capture register is not yet written, so encode straight from the input.
                load_byte = nibble_to_ascii(iData[7:4]);
            end
        end else if (tx_done) begin
            if (char_q == LastChar) begin
                busy_d = 1'b0;
            end else begin
                char_d    = char_nxt;
                load      = 1'b1;
                load_byte = seq_byte;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q <= '0;
            char_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            char_q <= char_d;
            busy_q <= busy_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_tx_byte (
        .clk_i (Clock),
        .rst_i (Reset),
        .load_i(load),
        .byte_i(load_byte),
        .done_o(tx_done),
        .tx_o  (oTx)
    );

    assign oReady = ~busy_q;
    assign oBusy  = busy_q;

endmodule

// File: tb/tb_led_hex_uart_tx.sv
// Directed bench for led_hex_uart_tx at CLKS_PER_BIT=4.
module tb_led_hex_uart_tx;

    localparam int CPB = 4;
`ifdef HEX_UART_CRLF_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 2;
`endif
    localparam int FRAME = NCH * 10 * CPB;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iValid = 1'b0;
    logic       oReady, oBusy, oTx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    led_hex_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .iData (iData),
        .iValid(iValid),
        .oReady(oReady),
        .oBusy (oBusy),
        .oTx   (oTx)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge; returns 1ns after edge number t.
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic accept(input logic [7:0] d, input bit hold, output int na);
        iData  = d;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        if (!hold) iValid = 1'b0;
        na = cyc;
        chk("accept_ready_busy", {30'd0, oReady, oBusy}, 32'b01);
        chk("start_latency_tx_still_high", {31'd0, oTx}, 32'd1);
    endtask

    // Samples every bit of the frame started at accept edge na and checks the characters
    // and the busy/ready window. With poke set, pulses iValid=0x55 mid-frame.
    task automatic rx_frame(input int na, input logic [7:0] e0, input logic [7:0] e1,
                            input string tag, input bit poke);
        logic [39:0] bits;
        logic [31:0] exp;
        logic        busy_ok;
        bits    = '0;
        busy_ok = 1'b1;
        exp     = {8'h0A, 8'h0D, e1, e0};
        for (int j = 0; j < 10 * NCH; j++) begin
            wait_cyc(na + 2 + CPB * j);
            bits[j] = oTx;
            if (!(oBusy === 1'b1 && oReady === 1'b0)) busy_ok = 1'b0;
            if (poke && j == 7) begin
                iData  = 8'h55;
                iValid = 1'b1;
            end
            if (poke && j == 8) iValid = 1'b0;
        end
        for (int k = 0; k < NCH; k++) begin
            chk({tag, "_char"}, {22'd0, bits[10*k +: 10]}, {22'd0, 1'b1, exp[8*k +: 8], 1'b0});
        end
        chk({tag, "_busy_during_frame"}, {31'd0, busy_ok}, 32'd1);
        wait_cyc(na + FRAME - 1);
        chk({tag, "_busy_last_cycle"}, {30'd0, oReady, oBusy}, 32'b01);
        wait_cyc(na + FRAME);
        chk({tag, "_idle_after_frame"}, {30'd0, oReady, oBusy}, 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int na;
        int na2;

        // 1: reset then idle
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_state", {29'd0, oTx, oReady, oBusy}, 32'b110);
        Reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge Clock);
            #1;
            chk("idle", {29'd0, oTx, oReady, oBusy}, 32'b110);
        end

        // 2: 0x3A -> '3' 'A'
        accept(8'h3A, 1'b0, na);
        rx_frame(na, 8'h33, 8'h41, "b3A", 1'b0);

        // 3: 0xF0 with iValid held; iData changed mid-frame becomes the second byte
        accept(8'hF0, 1'b1, na);
        iData = 8'h2B;
        rx_frame(na, 8'h46, 8'h30, "bF0", 1'b0);
        @(posedge Clock);
        #1;
        chk("b2B_accepted_next_edge", {30'd0, oReady, oBusy}, 32'b01);
        na2    = cyc;
        iValid = 1'b0;
        rx_frame(na2, 8'h32, 8'h42, "b2B", 1'b0);

        // 4: iValid pulse while busy is ignored
        accept(8'hA5, 1'b0, na);
        rx_frame(na, 8'h41, 8'h35, "bA5", 1'b1);
        wait_cyc(na + FRAME + 2);
        chk("no_queued_byte", {29'd0, oTx, oReady, oBusy}, 32'b110);

        // 5: reset during data bit 3 of the first char, with iValid asserted
        accept(8'h3A, 1'b0, na);
        wait_cyc(na + 18);
        chk("data_bit3_before_reset", {31'd0, oTx}, 32'd0);
        Reset  = 1'b1;
        iValid = 1'b1;
        iData  = 8'h77;
        @(posedge Clock);
        #1;
        chk("reset_abort", {29'd0, oTx, oReady, oBusy}, 32'b110);
        Reset  = 1'b0;
        iValid = 1'b0;
        @(posedge Clock);
        #1;
        chk("reset_beats_valid", {29'd0, oTx, oReady, oBusy}, 32'b110);
        accept(8'h09, 1'b0, na);
        rx_frame(na, 8'h30, 8'h39, "b09", 1'b0);

`ifdef HEX_UART_CRLF_EN
        // 6: CR/LF appended
        accept(8'hC7, 1'b0, na);
        rx_frame(na, 8'h43, 8'h37, "bC7", 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_hex_uart_tx.md
Name: led_hex_uart_tx

Overview:
- Sits directly downstream of the MiniAlu 8-bit LED output.
- Captures an 8-bit result byte and transmits it as two uppercase ASCII hex characters on an 8N1 UART line for host-side logging of ALU results.
- Single-entry valid/ready capture port; serial output idles high.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
CNT_W, 16, width of bit-period counter; must hold CLKS_PER_BIT-1

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
iData  input  8  byte to transmit (typically MiniAlu oLed)
iValid  input  1  iData valid; accepted when iValid & oReady at rising edge
oReady  output  1  high only when idle and able to accept a byte
oBusy  output  1  high from acceptance until the end of the last stop bit
oTx  output  1  UART serial line, idle high, registered output

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: oTx=1, oReady=1, oBusy=0, FSM=IDLE, all counters=0, capture register=0.
- Accept: iValid&oReady at edge N latches iData. oReady=0 and oBusy=1 from edge N onward.
- Start bit: oTx=0 from edge N+1, i.e. 1-cycle latency.
- FSM states: IDLE -> START -> DATA -> STOP -> (next char ? START : IDLE).
- Each state lasts exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1 and then wraps to 0.
- DATA: 8 bits, LSB first; a 3-bit index advances on each bit-counter wrap.
- STOP: 1 bit, oTx=1.
- Character sequence: high nibble char, then low nibble char. The second START follows the first STOP with no idle gap.
- Hex map: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10); uppercase only.
- Frame length: 20*CLKS_PER_BIT cycles without the optional feature.
- Return to idle: at the final STOP wrap, FSM goes to IDLE and oBusy=0. oReady=1 from that same edge, so back-to-back bytes are legal with no extra idle cycle.
- iValid while busy: ignored. There is no queueing, and iData changes mid-frame do not alter the frame in flight.
- Reset mid-frame: at the reset edge oTx=1 and the FSM returns to IDLE. The partial character is aborted, with no stop-bit completion.
- Simultaneous Reset and iValid: Reset wins and the byte is not accepted.
- CLKS_PER_BIT=2 must still produce correct waveforms. No combinational path from iValid to oTx.

Optional Feature:
- Macro: HEX_UART_CRLF_EN.
- Defined: after the two hex chars, send 0x0D then 0x0A. Frame becomes 4 chars, 40*CLKS_PER_BIT cycles, and the char index widens to 2 bits.
- Undefined: 2 chars only. oBusy/oReady timing changes accordingly.

Decomposition:
- Package led_hex_uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP) as localparam encodings.
  - ASCII constants: ASCII_0=0x30, ASCII_A=0x41, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - A nibble-to-ASCII function.
- One natural sub-module: uart_tx_byte.
  - Owns the start/data/stop bit timing for one byte, with a load/done handshake.
  - The top level sequences characters and owns the capture register and oReady/oBusy.

Test Plan:
1. Reset, then idle 50 cycles -> oTx=1, oReady=1, oBusy=0 throughout.
2. CLKS_PER_BIT=4; send iData=0x3A -> oTx carries 0x33 then 0x41. Bit sequence 0,1100 1100,1 then 0,1000 0010,1; start bit begins 1 cycle after accept; oBusy high for 80 cycles.
3. Send 0xF0 with iValid held high continuously -> '0xF'=0x46, '0'=0x30. A second byte is accepted on the edge oReady rises; zero idle cycles between frames.
4. Pulse iValid with 0x55 while busy mid-frame -> ignored; only the original byte is transmitted and oReady stays 0.
5. Assert Reset during the DATA bit 3 of the first char -> next edge oTx=1, oReady=1, oBusy=0. A new byte 0x09 afterwards yields 0x30, 0x39 correctly.
6. With HEX_UART_CRLF_EN: send 0xC7 -> chars 0x43, 0x37, 0x0D, 0x0A; oBusy high for 160 cycles at CLKS_PER_BIT=4.
